// File: rtl/hilo_muldiv_pkg.sv
// rtl/hilo_muldiv_pkg.sv - shared encodings for the HI/LO multiply/divide unit
// Contents:
//   op_e    : operation codes presented on op alongside start
//   state_e : control FSM states
//   ITERS   : default operand width, which is also the CALC iteration count
package hilo_muldiv_pkg;

  localparam int ITERS = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/hilo_muldiv_if.sv
// rtl/hilo_muldiv_if.sv - request/result bundle between the EX stage and the HI/LO unit
// Signals (master = pipeline, slave = hilo_muldiv):
//   start, op[1:0], a, b        : operation request and operands
//   hi_we, lo_we, wdata         : MTHI/MTLO writes
//   busy, done, div_by_zero     : status back to the pipeline
//   hi, lo                      : architectural HI/LO registers
interface hilo_muldiv_if
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH = ITERS
);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );

endinterface

// File: rtl/hilo_muldiv_cond_neg.sv
// rtl/hilo_muldiv_cond_neg.sv - conditional two's-complement negate
// Ports:
//   i_a   : value in
//   i_neg : 1 selects -i_a, 0 passes i_a through
//   o_y   : result
module hilo_muldiv_cond_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic         i_neg,
  output logic [W-1:0] o_y
);

  assign o_y = i_neg ? (-i_a) : i_a;

endmodule

// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
// Ports:
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : hilo_muldiv_if.slave (request, MTHI/MTLO writes, status, HI/LO)
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH = ITERS
) (
  input  logic          i_clk,
  input  logic          i_rst,
  hilo_muldiv_if.slave  bus
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e                 r_state;
  state_e                 w_next;
  logic [CW-1:0]          r_cnt;
  op_e                    r_op;
  logic                   r_neg_q;
  logic                   r_neg_r;
  logic                   r_dbz;
  // Multiply: multiplicand magnitude. Divide: divisor magnitude.
  logic [WIDTH-1:0]       r_opnd;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits / quotient bits}.
  logic [2*WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]       r_hi;
  logic [WIDTH-1:0]       r_lo;

  logic                   w_busy;
  logic                   w_accept;
  logic                   w_req_div;
  logic                   w_req_signed;
  logic                   w_req_dbz;
  logic                   w_run_div;

  logic                   w_neg_a_sel;
  logic                   w_neg_b_sel;
  logic [WIDTH-1:0]       w_neg_a_in;
  logic [WIDTH-1:0]       w_neg_b_in;
  logic [WIDTH-1:0]       w_neg_a_out;
  logic [WIDTH-1:0]       w_neg_b_out;
  logic [2*WIDTH-1:0]     w_prod_fix;

  logic [WIDTH:0]         w_madd;
  logic [WIDTH:0]         w_rem_sh;
  logic [WIDTH:0]         w_trial;
  logic [2*WIDTH-1:0]     w_acc_mul;
  logic [2*WIDTH-1:0]     w_acc_div;

  assign w_busy       = (r_state == S_CALC) || (r_state == S_FIX);
  assign w_accept     = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_req_div    = bus.op[1];
  assign w_req_signed = bus.op[0];
  assign w_req_dbz    = w_req_div && (bus.b == '0);
  assign w_run_div    = (r_op == OP_DIVU) || (r_op == OP_DIV);

  // The two 32-bit negators serve double duty: operand magnitudes on accept,
  // remainder/quotient sign fix in FIX. Accept never happens in FIX.
  assign w_neg_a_in  = (r_state == S_FIX) ? r_acc[2*WIDTH-1:WIDTH] : bus.a;
  assign w_neg_b_in  = (r_state == S_FIX) ? r_acc[WIDTH-1:0]       : bus.b;
  assign w_neg_a_sel = (r_state == S_FIX) ? r_neg_r : (w_req_signed & bus.a[WIDTH-1]);
  assign w_neg_b_sel = (r_state == S_FIX) ? r_neg_q : (w_req_signed & bus.b[WIDTH-1]);

  hilo_muldiv_cond_neg #(.W(WIDTH)) u_neg_a (
    .i_a   (w_neg_a_in),
    .i_neg (w_neg_a_sel),
    .o_y   (w_neg_a_out)
  );

  hilo_muldiv_cond_neg #(.W(WIDTH)) u_neg_b (
    .i_a   (w_neg_b_in),
    .i_neg (w_neg_b_sel),
    .o_y   (w_neg_b_out)
  );

  hilo_muldiv_cond_neg #(.W(2*WIDTH)) u_neg_p (
    .i_a   (r_acc),
    .i_neg (r_neg_q),
    .o_y   (w_prod_fix)
  );

  // Shift-add step: conditionally add multiplicand to the upper half (with
  // carry), then shift the whole accumulator right one place.
  assign w_madd    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_acc_mul = {w_madd, r_acc[WIDTH-1:1]};

  // Restoring step: shifted remainder needs WIDTH+1 bits since it can reach
  // 2*divisor-1; the borrow bit of the trial tells whether to restore.
  assign w_rem_sh  = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_trial   = w_rem_sh - {1'b0, r_opnd};
  assign w_acc_div = w_trial[WIDTH]
                   ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                   : {w_trial[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next          = r_state;
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    bus.div_by_zero = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = w_req_dbz ? S_FIX : S_CALC;
      end
      S_CALC: begin
        bus.busy = 1'b1;
        if (r_cnt == LAST) w_next = S_FIX;
      end
      S_FIX: begin
        bus.busy = 1'b1;
        w_next   = S_DONE;
      end
      S_DONE: begin
        bus.done        = 1'b1;
        bus.div_by_zero = r_dbz;
        if (bus.start) w_next = w_req_dbz ? S_FIX : S_CALC;
        else           w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_op    <= OP_MULTU;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dbz   <= 1'b0;
      r_opnd  <= '0;
      r_acc   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      // MT writes land even on the edge that accepts a new op; FIX overwrites later.
      if (!w_busy) begin
        if (bus.hi_we) r_hi <= bus.wdata;
        if (bus.lo_we) r_lo <= bus.wdata;
      end

      if (w_accept) begin
        r_op    <= op_e'(bus.op);
        r_cnt   <= '0;
        r_dbz   <= w_req_dbz;
        r_neg_q <= w_req_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        r_neg_r <= w_req_signed & bus.a[WIDTH-1];
        if (w_req_div) begin
          r_opnd <= w_neg_b_out;
          // Divide-by-zero keeps the raw dividend so FIX can copy it to HI.
          r_acc  <= {{WIDTH{1'b0}}, (w_req_dbz ? bus.a : w_neg_a_out)};
        end else begin
          r_opnd <= w_neg_a_out;
          r_acc  <= {{WIDTH{1'b0}}, w_neg_b_out};
        end
      end else begin
        case (r_state)
          S_CALC: begin
            r_acc <= w_run_div ? w_acc_div : w_acc_mul;
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
          end
          S_FIX: begin
            if (r_dbz) begin
              r_hi <= r_acc[WIDTH-1:0];
              r_lo <= '1;
            end else if (w_run_div) begin
              r_hi <= w_neg_a_out;
              r_lo <= w_neg_b_out;
            end else begin
              r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
              r_lo <= w_prod_fix[WIDTH-1:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.hi = r_hi;
  assign bus.lo = r_lo;

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb/tb_hilo_muldiv.sv - scoreboard bench for hilo_muldiv
module tb_hilo_muldiv;

  localparam logic [1:0] MULTU = 2'b00;
  localparam logic [1:0] MULT  = 2'b01;
  localparam logic [1:0] DIVU  = 2'b10;
  localparam logic [1:0] DIV   = 2'b11;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  exp_t sb[$];

  hilo_muldiv_if #(.WIDTH(32)) bus ();

  hilo_muldiv #(.WIDTH(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_hi"},  {32'd0, bus.hi}, {32'd0, e.hi});
          chk({e.name, "_lo"},  {32'd0, bus.lo}, {32'd0, e.lo});
          chk({e.name, "_dbz"}, {63'd0, bus.div_by_zero}, {63'd0, e.dbz});
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic hwe, input logic lwe, input logic [31:0] wd);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.hi_we = hwe;
    bus.lo_we = lwe;
    bus.wdata = wd;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
  endtask

  // Counts negedges until done; elat/ebusy are relative to the call point.
  task automatic wait_done(input string name, input int elat, input int ebusy);
    int lat;
    int bc;
    bit got;
    lat = 0;
    bc  = 0;
    got = 0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (bus.busy === 1'b1) bc++;
      if (bus.done === 1'b1) got = 1;
    end
    if (!got) begin
      chk({name, "_timeout"}, 64'd0, 64'd1);
    end else begin
      chk({name, "_latency"}, 64'(lat), 64'(elat));
      chk({name, "_busy_cycles"}, 64'(bc), 64'(ebusy));
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edbz);
    bit dz;
    dz = op[1] && (b == 32'd0);
    sb.push_back('{name, ehi, elo, edbz});
    issue(op, a, b, 1'b0, 1'b0, 32'd0);
    if (dz) wait_done(name, 2, 1);
    else    wait_done(name, 34, 33);
  endtask

  initial begin
    int ndone;
    n_cmp     = 0;
    n_fail    = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;

    #2 rst = 1'b1;
    #1;
    chk("rst_hi",   {32'd0, bus.hi}, 64'd0);
    chk("rst_lo",   {32'd0, bus.lo}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_dbz",  {63'd0, bus.div_by_zero}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op("multu_max",  MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_neg",   MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("div_neg",    DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_zero",  DIVU,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
    run_op("divu_100_7", DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
    run_op("div_minovf", DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("mult_min2",  MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    run_op("divu_big",   DIVU,  32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 32'h0FFF_FFFF, 1'b0);
    run_op("multu_shft", MULTU, 32'h1234_5678, 32'h10,        32'h0000_0001, 32'h2345_6780, 1'b0);

    // Start and hi_we while busy are both ignored; HI holds through CALC.
    sb.push_back('{"busy_collide", 32'd0, 32'd42, 1'b0});
    issue(MULTU, 32'd6, 32'd7, 1'b0, 1'b0, 32'd0);
    repeat (9) @(negedge clk);
    issue(DIV, 32'd99, 32'd3, 1'b1, 1'b0, 32'hDEAD_BEEF);
    chk("calc_hi_hold", {32'd0, bus.hi}, 64'd1);
    wait_done("busy_collide", 24, 23);

    // MT writes in IDLE.
    @(negedge clk);
    bus.hi_we = 1'b1;
    bus.wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 bus.hi_we = 1'b0;
    chk("mthi_hi", {32'd0, bus.hi}, {32'd0, 32'hDEAD_BEEF});
    chk("mthi_lo", {32'd0, bus.lo}, 64'd42);
    @(negedge clk);
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0BAD_F00D;
    @(posedge clk);
    #1 bus.lo_we = 1'b0;
    chk("mtlo_lo", {32'd0, bus.lo}, {32'd0, 32'h0BAD_F00D});

    // Same-edge MTHI and start: write lands now, FIX overwrites later.
    sb.push_back('{"same_edge", 32'd0, 32'd6, 1'b0});
    issue(MULTU, 32'd2, 32'd3, 1'b1, 1'b0, 32'h0000_0055);
    chk("same_edge_mthi", {32'd0, bus.hi}, 64'h55);
    wait_done("same_edge", 34, 33);

    // Async reset mid-divide: clears between clock edges, no done afterwards.
    issue(DIV, 32'd1000, 32'd3, 1'b0, 1'b0, 32'd0);
    repeat (14) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_hi",   {32'd0, bus.hi}, 64'd0);
    chk("arst_lo",   {32'd0, bus.lo}, 64'd0);
    chk("arst_busy", {63'd0, bus.busy}, 64'd0);
    chk("arst_done", {63'd0, bus.done}, 64'd0);
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
    end
    chk("arst_quiet", 64'(ndone), 64'd0);
    run_op("post_rst_divu", DIVU, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
